stopwatch_counter: RTL

Time-keeping core of the stopwatch: it produces the `minutes`/`seconds` values and the `paused` flag that the seven-segment display driver consumes. It counts MM:SS from 1 Hz enable ticks and supports adjust mode, where the selected field advances at the faster adjust rate. It also conditions the raw pause button: synchronise, debounce, detect the rising edge, then toggle. All state runs in one clock domain. Tick enables come from the clock-divider block.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/button_debouncer.sv | 48 ++++
 rtl/stopwatch_counter.sv | 87 ++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared time-field types and constants for the stopwatch
package stopwatch_pkg;

    localparam int TIME_W = 6;

    typedef logic [TIME_W-1:0] time_field_t;

    localparam time_field_t MAX_FIELD = time_field_t'(59);

    // Advance a field by one, wrapping 59 -> 0; anything at or above 59 wraps
    function automatic time_field_t inc_field(input time_field_t f);
        return (f >= MAX_FIELD) ? '0 : f + time_field_t'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser, stable-count debouncer and rising-edge detector
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetN,
    input  logic btnRaw,
    output logic btnLevel,
    output logic btnRise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchroniser, then accept a new level only after it has
    // disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1   <= btnRaw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign btnLevel = level;
    assign btnRise  = level & ~level_d;

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS counter with adjust mode and debounced pause toggle
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              incTick,
    input  logic              adjTick,
    input  logic              adj,
    input  logic              sel,
    input  logic              pauseBtn,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              paused,
    output logic              wrapPulse
);

    time_field_t min_q;
    time_field_t sec_q;
    time_field_t min_d;
    time_field_t sec_d;
    logic        paused_q;
    logic        wrap_q;
    logic        wrap_d;
    logic        pause_rise;
    logic        btn_level_unused;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause_debouncer (
        .clk     (clk),
        .resetN  (resetN),
        .btnRaw  (pauseBtn),
        .btnLevel(btn_level_unused),
        .btnRise (pause_rise)
    );

    // Next count: only the tick matching the current mode counts, and the
    // pre-toggle paused value gates it
    always_comb begin
        min_d  = min_q;
        sec_d  = sec_q;
        wrap_d = 1'b0;
        if (!paused_q) begin
            if (!adj) begin
                if (incTick) begin
                    sec_d = inc_field(sec_q);
                    if (sec_q >= MAX_FIELD) begin
                        min_d  = inc_field(min_q);
                        wrap_d = (min_q >= MAX_FIELD);
                    end
                end
            end else if (adjTick) begin
                if (sel) begin
                    sec_d = inc_field(sec_q);
                end else begin
                    min_d = inc_field(min_q);
                end
            end
        end
    end

    // Field registers, wrap pulse and pause toggle
    always_ff @(posedge clk) begin
        if (!resetN) begin
            min_q    <= '0;
            sec_q    <= '0;
            wrap_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            sec_q  <= sec_d;
            wrap_q <= wrap_d;
            if (pause_rise) begin
                paused_q <= ~paused_q;
            end
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign paused    = paused_q;
    assign wrapPulse = wrap_q;

endmodule
